// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter that owns the select of a shared N:1 bit mux and forwards the owner's data bit.
// Latency: a request present at an edge is granted at that edge (grant/select/valid registered); answer is combinational.
// Backpressure: an owner keeps the mux while it holds req; after MAX_HOLD cycles it is pre-empted if others wait.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   req[N]              request vector, bit i = requester i wants the mux
//   inputs[N]           mux data bits, one per requester
//   grant[N]            one-hot grant (0 when idle), registered
//   grant_valid         1 while a grant is active, registered
//   selectbits[SELW]    index of the current owner, registered (mux select)
//   answer              inputs[selectbits] while grant_valid, else 0
//   lock                only with ARB_LOCK_EN defined: suppresses pre-emption and freezes hold_cnt
//
// Build option: define ARB_LOCK_EN to add the lock input.
module rr_mux_arbiter #(
  parameter int N        = 4,
  parameter int SELW     = 2,
  parameter int MAX_HOLD = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    inputs,
`ifdef ARB_LOCK_EN
  input  logic            lock,
`endif
  output logic [N-1:0]    grant,
  output logic            grant_valid,
  output logic [SELW-1:0] selectbits,
  output logic            answer
);

  localparam int HW = $clog2(MAX_HOLD) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, state_nxt;
  logic [SELW-1:0] ptr, ptr_nxt;
  logic [SELW-1:0] sel_nxt;
  logic [N-1:0]    grant_nxt;
  logic            valid_nxt;
  logic [HW-1:0]   hold_cnt, hold_nxt;
  logic            new_grant;
  logic [N-1:0]    cand;
  logic [SELW-1:0] win;
  logic            owner_req;
  logic [N-1:0]    others;
  logic            lock_act;

`ifdef ARB_LOCK_EN
  assign lock_act = lock;
`else
  assign lock_act = 1'b0;
`endif

  // First set bit of cand searching start, start+1, ... with wrap modulo N.
  // Iterating from the far end lets the nearest hit overwrite the result.
  function automatic logic [SELW-1:0] pick(input logic [N-1:0] c, input logic [SELW-1:0] start);
    logic [SELW-1:0] idx;
    logic [SELW-1:0] res;
    res = start;
    for (int i = N - 1; i >= 0; i--) begin
      idx = start + SELW'(i);
      if (c[idx]) res = idx;
    end
    return res;
  endfunction

  assign owner_req = req[selectbits];
  assign others    = req & ~grant;
  assign answer    = grant_valid & inputs[selectbits];

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    sel_nxt   = selectbits;
    grant_nxt = grant;
    valid_nxt = grant_valid;
    hold_nxt  = hold_cnt;
    new_grant = 1'b0;
    cand      = req;
    win       = '0;

    case (state)
      IDLE: begin
        if (|req) new_grant = 1'b1;
      end
      GRANT: begin
        if (!owner_req) begin
          // Release takes precedence over a coincident pre-emption.
          if (|req) begin
            new_grant = 1'b1;
          end else begin
            state_nxt = IDLE;
            grant_nxt = '0;
            valid_nxt = 1'b0;
            sel_nxt   = '0;
          end
        end else if (!lock_act && hold_cnt == HOLD_LAST && |others) begin
          new_grant = 1'b1;
          cand      = others;
        end else if (!lock_act && hold_cnt != HOLD_LAST) begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
    endcase

    if (new_grant) begin
      win            = pick(cand, ptr);
      state_nxt      = GRANT;
      sel_nxt        = win;
      grant_nxt      = '0;
      grant_nxt[win] = 1'b1;
      valid_nxt      = 1'b1;
      ptr_nxt        = win + 1'b1;
      hold_nxt       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      hold_cnt    <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      selectbits  <= '0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      hold_cnt    <= hold_nxt;
      grant       <= grant_nxt;
      grant_valid <= valid_nxt;
      selectbits  <= sel_nxt;
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter (N=4, MAX_HOLD=4).
// Stimulus pushes the hand-computed post-edge response; a monitor pops and compares after each edge.
// Lock scenario is built only when ARB_LOCK_EN is defined.
module tb_rr_mux_arbiter;

  typedef struct packed {
    logic [3:0] g;
    logic       v;
    logic [1:0] s;
    logic       a;
    int         tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       lock;
  logic [3:0] req;
  logic [3:0] inputs;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] selectbits;
  logic       answer;

  int   checks = 0;
  int   passes = 0;
  int   stepno = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  rr_mux_arbiter #(.N(4), .SELW(2), .MAX_HOLD(4)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .inputs(inputs),
`ifdef ARB_LOCK_EN
    .lock(lock),
`endif
    .grant(grant),
    .grant_valid(grant_valid),
    .selectbits(selectbits),
    .answer(answer)
  );

  task automatic chk(input string name, input int tag, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s step %0d: got %b expected %b", name, tag, act, exp);
  endtask

  // Drive one cycle of inputs on the falling edge and queue the response expected after the next rising edge.
  task automatic step(input logic rs, input logic [3:0] r, input logic [3:0] d, input logic lk,
                      input logic [3:0] eg, input logic [1:0] es, input logic ev, input logic ea);
    exp_t e;
    @(negedge clk);
    reset  = rs;
    req    = r;
    inputs = d;
    lock   = lk;
    stepno++;
    e.g = eg; e.v = ev; e.s = es; e.a = ea; e.tag = stepno;
    q.push_back(e);
  endtask

  // Monitor: compare every queued expectation just after the edge it belongs to.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("grant",       e.tag, grant,                   e.g);
      chk("grant_valid", e.tag, {3'b000, grant_valid},   {3'b000, e.v});
      chk("selectbits",  e.tag, {2'b00, selectbits},     {2'b00, e.s});
      chk("answer",      e.tag, {3'b000, answer},        {3'b000, e.a});
      chk("onehot0",     e.tag, {3'b000, $onehot0(grant)}, 4'b0001);
      chk("grant_at_sel", e.tag, {3'b000, (!grant_valid || grant[selectbits])}, 4'b0001);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int o;
    reset  = 1'b1;
    req    = 4'b0000;
    inputs = 4'b0000;
    lock   = 1'b0;

    // Reset with all requests asserted: everything stays 0.
    repeat (2) step(1'b1, 4'b1111, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Lone requester 2 is granted on the first edge and never pre-empted.
    repeat (22) step(1'b0, 4'b0100, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b1);
    // Owner drops, nobody waiting: idle, answer forced 0 despite inputs=1111.
    step(1'b0, 4'b0000, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Reset to bring ptr back to 0, then full contention: owners 0,1,2,3,0 for 4 cycles each.
    step(1'b1, 4'b1111, 4'b1010, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
    for (int t = 0; t < 20; t++) begin
      o = (t / 4) % 4;
      step(1'b0, 4'b1111, 4'b1010, 1'b0, 4'(1 << o), o[1:0], 1'b1, o[0]);
    end

    // Owner 0 pre-empted in favour of 1; owner 1 then drops with only 3 waiting.
    step(1'b0, 4'b1111, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b1);
    step(1'b0, 4'b1000, 4'b1010, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b1);
    step(1'b0, 4'b0000, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Reset mid-grant of owner 2 (ptr would be 3) while req=1111; afterwards ptr restarts at 0.
    step(1'b0, 4'b0100, 4'b1010, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
    step(1'b0, 4'b0100, 4'b1010, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
    step(1'b1, 4'b1111, 4'b1010, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
    step(1'b0, 4'b1111, 4'b1010, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);

    // Owner 0 releases on the very cycle it would be pre-empted: released, next in order (1) wins.
    repeat (3) step(1'b0, 4'b1111, 4'b1010, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    step(1'b0, 4'b1110, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b1);

`ifdef ARB_LOCK_EN
    // Owner 0 reaches its hold limit, lock keeps it for 10 cycles total; dropping lock pre-empts at once.
    step(1'b1, 4'b1111, 4'b1010, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
    repeat (4) step(1'b0, 4'b1111, 4'b1010, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    repeat (6) step(1'b0, 4'b1111, 4'b1010, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0);
    step(1'b0, 4'b1111, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b1);
`endif

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() == 0) passes++;
    else $display("FAIL drain: %0d expectations left, required 0", q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
